// File: rtl/spi_flash_reader_multi.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_reader_multi
// Brief    : Read-only SPI NOR flash master with single/dual/quad data phase.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_reader_multi #(
  parameter int ADDRESS_WIDTH   = 24,
  parameter int LENGTH_WIDTH    = 16,
  parameter int DUMMY_CYCLES    = 8,
  parameter int CSN_IDLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     read_start,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [LENGTH_WIDTH-1:0]  read_length,
  output logic                     busy,
  output logic [7:0]               data,
  output logic                     data_valid,
  output logic                     flash_sck,
  output logic                     flash_csn,
  output logic [3:0]               flash_io_out,
  output logic [3:0]               flash_io_oe,
  input  logic [3:0]               flash_io_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [7:0]              c_dummy_last = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0]              c_gap_last   = 8'(CSN_IDLE_CYCLES - 1);
  localparam logic [LENGTH_WIDTH-1:0] c_len_one    = LENGTH_WIDTH'(1);
  localparam logic [3:0]              c_io_out_idle = 4'b1100;
  localparam logic [3:0]              c_io_oe_idle  = 4'b1101;

  state_t                  r_state;
  logic [1:0]              r_mode;
  logic [30:0]             r_sr;
  logic [7:0]              r_bitcnt;
  logic [7:0]              r_gapcnt;
  logic [7:0]              r_shin;
  logic [LENGTH_WIDTH-1:0] r_len;
  logic                    r_busy;
  logic [7:0]              r_data;
  logic                    r_data_valid;
  logic                    r_sck;
  logic                    r_csn;
  logic [3:0]              r_io_out;
  logic [3:0]              r_io_oe;

  logic [1:0]  w_mode_eff;
  logic [7:0]  w_cmd;
  logic [23:0] w_addr24;
  logic [7:0]  w_shift_in;
  logic [7:0]  w_byte_last;
  logic [3:0]  w_data_oe;

  // Flash address field is always 24 bits on the wire.
  generate
    if (ADDRESS_WIDTH >= 24) begin : g_addr_trunc
      assign w_addr24 = read_address[23:0];
    end else begin : g_addr_zext
      assign w_addr24 = {{(24-ADDRESS_WIDTH){1'b0}}, read_address};
    end
  endgenerate

  always_comb begin
    w_mode_eff = (mode == 2'd3) ? 2'd0 : mode;
    case (w_mode_eff)
      2'd1:    w_cmd = 8'h3B;
      2'd2:    w_cmd = 8'h6B;
      default: w_cmd = 8'h03;
    endcase
    case (r_mode)
      2'd1: begin
        w_shift_in  = {r_shin[5:0], flash_io_in[1:0]};
        w_byte_last = 8'd3;
        w_data_oe   = 4'b1100;
      end
      2'd2: begin
        w_shift_in  = {r_shin[3:0], flash_io_in};
        w_byte_last = 8'd1;
        w_data_oe   = 4'b0000;
      end
      default: begin
        w_shift_in  = {r_shin[6:0], flash_io_in[1]};
        w_byte_last = 8'd7;
        w_data_oe   = 4'b1101;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'd0;
      r_sr         <= '0;
      r_bitcnt     <= '0;
      r_gapcnt     <= '0;
      r_shin       <= '0;
      r_len        <= '0;
      r_busy       <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_sck        <= 1'b0;
      r_csn        <= 1'b1;
      r_io_out     <= c_io_out_idle;
      r_io_oe      <= c_io_oe_idle;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read_start && (read_length != '0)) begin
            r_state     <= S_CMD;
            r_mode      <= w_mode_eff;
            r_len       <= read_length;
            r_sr        <= {w_cmd[6:0], w_addr24};
            r_bitcnt    <= '0;
            r_busy      <= 1'b1;
            r_csn       <= 1'b0;
            r_sck       <= 1'b0;
            r_io_out    <= {3'b110, w_cmd[7]};
            r_io_oe     <= c_io_oe_idle;
          end
        end
        S_CMD, S_ADDR: begin
          r_sck <= ~r_sck;
          if (r_sck) begin
            // Next bit is presented as SCK falls.
            r_sr        <= {r_sr[29:0], 1'b0};
            r_io_out[0] <= r_sr[30];
            r_bitcnt    <= r_bitcnt + 8'd1;
            if (r_state == S_CMD && r_bitcnt == 8'd7) begin
              r_state  <= S_ADDR;
              r_bitcnt <= '0;
            end else if (r_state == S_ADDR && r_bitcnt == 8'd23) begin
              r_bitcnt <= '0;
              r_io_out <= c_io_out_idle;
              r_io_oe  <= w_data_oe;
              r_state  <= (r_mode == 2'd0 || DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          r_sck <= ~r_sck;
          if (r_sck) begin
            r_bitcnt <= r_bitcnt + 8'd1;
            if (r_bitcnt == c_dummy_last) begin
              r_bitcnt <= '0;
              r_state  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          r_sck <= ~r_sck;
          if (r_sck) begin
            r_shin   <= w_shift_in;
            r_bitcnt <= r_bitcnt + 8'd1;
            if (r_bitcnt == w_byte_last) begin
              r_bitcnt     <= '0;
              r_data       <= w_shift_in;
              r_data_valid <= 1'b1;
              r_len        <= r_len - c_len_one;
              if (r_len == c_len_one) begin
                r_state  <= S_GAP;
                r_csn    <= 1'b1;
                r_sck    <= 1'b0;
                r_io_out <= c_io_out_idle;
                r_io_oe  <= c_io_oe_idle;
                r_gapcnt <= '0;
              end
            end
          end
        end
        S_GAP: begin
          r_gapcnt <= r_gapcnt + 8'd1;
          if (r_gapcnt == c_gap_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign data         = r_data;
  assign data_valid   = r_data_valid;
  assign flash_sck    = r_sck;
  assign flash_csn    = r_csn;
  assign flash_io_out = r_io_out;
  assign flash_io_oe  = r_io_oe;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_reader_multi
// Brief    : Scoreboard bench with a behavioural SPI flash for the reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        read_start;
  logic [23:0] read_address;
  logic [15:0] read_length;
  logic        busy;
  logic [7:0]  data;
  logic        data_valid;
  logic        flash_sck;
  logic        flash_csn;
  logic [3:0]  flash_io_out;
  logic [3:0]  flash_io_oe;
  logic [3:0]  flash_io_in = 4'b0000;

  spi_flash_reader_multi #(
    .ADDRESS_WIDTH(24), .LENGTH_WIDTH(16), .DUMMY_CYCLES(8), .CSN_IDLE_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .read_start(read_start),
    .read_address(read_address), .read_length(read_length), .busy(busy),
    .data(data), .data_valid(data_valid), .flash_sck(flash_sck),
    .flash_csn(flash_csn), .flash_io_out(flash_io_out),
    .flash_io_oe(flash_io_oe), .flash_io_in(flash_io_in)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  int t_start  = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int bytes_seen = 0;
  logic [7:0] exp_data_q[$];
  int         exp_cyc_q[$];
  logic [7:0] m_ed;
  int         m_ec;

  always @(posedge clk) edge_cnt++;

  // Flash model: captures cmd+addr on rising SCK, drives read data on falling SCK.
  int          m_rises   = 0;
  int          sck_total = 0;
  logic [31:0] m_sr      = '0;
  logic [7:0]  model_mem[0:7];

  always @(posedge flash_sck or posedge flash_csn) begin
    if (flash_sck) sck_total++;
    if (flash_csn) m_rises = 0;
    else begin
      if (m_rises < 32) m_sr = {m_sr[30:0], flash_io_out[0]};
      m_rises++;
    end
  end

  always @(negedge flash_sck) begin : model_drive
    int w, dmy, k, cpb, bi, ch;
    logic [7:0] b;
    if (flash_csn === 1'b0) begin
      w   = (m_sr[31:24] == 8'h3B) ? 2 : (m_sr[31:24] == 8'h6B) ? 4 : 1;
      dmy = (w == 1) ? 0 : 8;
      if (m_rises >= 32 + dmy) begin
        k   = m_rises - 32 - dmy;
        cpb = 8 / w;
        bi  = k / cpb;
        ch  = k % cpb;
        b   = model_mem[bi % 8] >> (8 - w * (ch + 1));
        case (w)
          1:       flash_io_in = {2'b00, b[0], 1'b0};
          2:       flash_io_in = {2'b00, b[1:0]};
          default: flash_io_in = b[3:0];
        endcase
      end else begin
        flash_io_in = 4'b0000;
      end
    end
  end

  // Scoreboard: every data_valid pops one expected (byte, cycle) pair.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      bytes_seen++;
      n_checks++;
      if (exp_data_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: data=%h at cycle %0d, required no data_valid",
                 data, edge_cnt - t_start);
      end else begin
        m_ed = exp_data_q.pop_front();
        m_ec = exp_cyc_q.pop_front();
        if (data !== m_ed || (edge_cnt - t_start) != m_ec) begin
          n_fail++;
          $display("FAIL byte: data=%h cycle=%0d, required data=%h cycle=%0d",
                   data, edge_cnt - t_start, m_ed, m_ec);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input int cyc);
    exp_data_q.push_back(d);
    exp_cyc_q.push_back(cyc);
  endtask

  task automatic start_read(input logic [1:0] m, input logic [23:0] a, input logic [15:0] l);
    @(negedge clk);
    mode = m; read_address = a; read_length = l; read_start = 1'b1;
    t_start = edge_cnt;
    @(negedge clk);
    read_start = 1'b0;
  endtask

  task automatic tick_to(input int n);
    while ((edge_cnt - t_start) < n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; read_start = 1'b0; mode = 2'd0; read_address = '0; read_length = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({flash_csn, flash_sck, busy, data_valid} !== 4'b1000 || data !== 8'h00 ||
        flash_io_out !== 4'b1100 || flash_io_oe !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_state: csn/sck/busy/dv=%b data=%h out=%b oe=%b, required 1000 00 1100 1101",
               {flash_csn, flash_sck, busy, data_valid}, data, flash_io_out, flash_io_oe);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    model_mem[0] = 8'hA5; model_mem[1] = 8'h3C;
    push_exp(8'hA5, 81); push_exp(8'h3C, 97);
    start_read(2'd0, 24'h123456, 16'd2);
    n_checks++;
    if ({flash_csn, flash_sck, busy, flash_io_out[0]} !== 4'b0010 || flash_io_oe !== 4'b1101) begin
      n_fail++;
      $display("FAIL single_cycle1: csn/sck/busy/io0=%b oe=%b, required 0010 1101",
               {flash_csn, flash_sck, busy, flash_io_out[0]}, flash_io_oe);
    end
    tick_to(2);
    n_checks++;
    if (flash_sck !== 1'b1) begin
      n_fail++; $display("FAIL single_sck_cycle2: sck=%b, required 1", flash_sck);
    end
    tick_to(97);
    n_checks++;
    if ({flash_csn, flash_sck, busy} !== 3'b101 || flash_io_out !== 4'b1100 || flash_io_oe !== 4'b1101) begin
      n_fail++;
      $display("FAIL single_end97: csn/sck/busy=%b out=%b oe=%b, required 101 1100 1101",
               {flash_csn, flash_sck, busy}, flash_io_out, flash_io_oe);
    end
    tick_to(98);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy98: busy=%b, required 1", busy); end
    tick_to(99);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy99: busy=%b, required 0", busy); end
    n_checks++;
    if (m_sr !== 32'h03123456) begin
      n_fail++; $display("FAIL single_cmdaddr: got %h, required 03123456", m_sr);
    end
  endtask

  task automatic test_dual;
    model_mem[0] = 8'h11; model_mem[1] = 8'h22; model_mem[2] = 8'h33;
    push_exp(8'h11, 89); push_exp(8'h22, 97); push_exp(8'h33, 105);
    start_read(2'd1, 24'h000100, 16'd3);
    tick_to(70);
    n_checks++;
    if (flash_io_oe !== 4'b1100 || flash_io_out[3:2] !== 2'b11) begin
      n_fail++; $display("FAIL dual_dummy_pins: oe=%b out=%b, required oe=1100 out[3:2]=11", flash_io_oe, flash_io_out);
    end
    tick_to(95);
    n_checks++;
    if (flash_io_oe !== 4'b1100 || flash_io_out[3:2] !== 2'b11 || flash_csn !== 1'b0) begin
      n_fail++; $display("FAIL dual_data_pins: oe=%b out=%b csn=%b, required 1100 11xx 0", flash_io_oe, flash_io_out, flash_csn);
    end
    tick_to(105);
    n_checks++;
    if (flash_csn !== 1'b1) begin n_fail++; $display("FAIL dual_csn105: csn=%b, required 1", flash_csn); end
    tick_to(107);
    n_checks++;
    if (busy !== 1'b0 || m_sr !== 32'h3B000100) begin
      n_fail++; $display("FAIL dual_end: busy=%b cmdaddr=%h, required 0 3B000100", busy, m_sr);
    end
  endtask

  task automatic test_quad;
    model_mem[0] = 8'h9E;
    push_exp(8'h9E, 85);
    start_read(2'd2, 24'hFFFFFF, 16'd1);
    tick_to(70);
    n_checks++;
    if (flash_io_oe !== 4'b0000) begin n_fail++; $display("FAIL quad_dummy_oe: oe=%b, required 0000", flash_io_oe); end
    tick_to(84);
    n_checks++;
    if (flash_io_oe !== 4'b0000 || flash_csn !== 1'b0) begin
      n_fail++; $display("FAIL quad_data_pins: oe=%b csn=%b, required 0000 0", flash_io_oe, flash_csn);
    end
    tick_to(85);
    n_checks++;
    if (flash_csn !== 1'b1 || flash_io_oe !== 4'b1101) begin
      n_fail++; $display("FAIL quad_end85: csn=%b oe=%b, required 1 1101", flash_csn, flash_io_oe);
    end
    tick_to(87);
    n_checks++;
    if (busy !== 1'b0 || m_sr !== 32'h6BFFFFFF) begin
      n_fail++; $display("FAIL quad_end: busy=%b cmdaddr=%h, required 0 6BFFFFFF", busy, m_sr);
    end
  endtask

  task automatic test_zero_length;
    int s;
    s = sck_total;
    start_read(2'd0, 24'h000010, 16'd0);
    tick_to(20);
    n_checks++;
    if (flash_csn !== 1'b1 || busy !== 1'b0 || sck_total != s) begin
      n_fail++; $display("FAIL zero_length: csn=%b busy=%b sck_edges=%0d, required 1 0 0",
                         flash_csn, busy, sck_total - s);
    end
  endtask

  task automatic test_ignore_busy;
    int b0;
    b0 = bytes_seen;
    model_mem[0] = 8'h5A; model_mem[1] = 8'hC3;
    push_exp(8'h5A, 81); push_exp(8'hC3, 97);
    start_read(2'd0, 24'h000200, 16'd2);
    tick_to(30);
    mode = 2'd2; read_length = 16'd5; read_start = 1'b1;
    @(negedge clk);
    read_start = 1'b0;
    tick_to(99);
    n_checks++;
    if (busy !== 1'b0 || bytes_seen - b0 != 2) begin
      n_fail++; $display("FAIL ignore_busy_end: busy=%b bytes=%0d, required 0 2", busy, bytes_seen - b0);
    end
    tick_to(150);
    n_checks++;
    if (busy !== 1'b0 || flash_csn !== 1'b1 || bytes_seen - b0 != 2) begin
      n_fail++; $display("FAIL ignore_busy_after: busy=%b csn=%b bytes=%0d, required 0 1 2",
                         busy, flash_csn, bytes_seen - b0);
    end
  endtask

  task automatic test_reset_mid;
    model_mem[0] = 8'h77; model_mem[1] = 8'h88;
    start_read(2'd0, 24'h000400, 16'd2);
    tick_to(40);
    reset = 1'b1;
    tick_to(41);
    n_checks++;
    if ({flash_csn, flash_sck, busy, data_valid} !== 4'b1000 || data !== 8'h00 ||
        flash_io_out !== 4'b1100 || flash_io_oe !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_mid41: csn/sck/busy/dv=%b data=%h out=%b oe=%b, required 1000 00 1100 1101",
               {flash_csn, flash_sck, busy, data_valid}, data, flash_io_out, flash_io_oe);
    end
    reset = 1'b0;
    tick_to(120);
    n_checks++;
    if (busy !== 1'b0 || flash_csn !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_quiet: busy=%b csn=%b, required 0 1", busy, flash_csn);
    end
    model_mem[0] = 8'hE1;
    push_exp(8'hE1, 81);
    start_read(2'd0, 24'h000500, 16'd1);
    tick_to(83);
    n_checks++;
    if (busy !== 1'b0 || m_sr !== 32'h03000500) begin
      n_fail++; $display("FAIL reset_mid_reread: busy=%b cmdaddr=%h, required 0 03000500", busy, m_sr);
    end
  endtask

  task automatic test_mode3;
    model_mem[0] = 8'hC3;
    push_exp(8'hC3, 81);
    start_read(2'd3, 24'h000010, 16'd1);
    tick_to(66);
    n_checks++;
    if (flash_io_oe !== 4'b1101 || flash_csn !== 1'b0) begin
      n_fail++; $display("FAIL mode3_data_oe: oe=%b csn=%b, required 1101 0", flash_io_oe, flash_csn);
    end
    tick_to(81);
    n_checks++;
    if (flash_csn !== 1'b1) begin n_fail++; $display("FAIL mode3_csn81: csn=%b, required 1", flash_csn); end
    tick_to(83);
    n_checks++;
    if (busy !== 1'b0 || m_sr !== 32'h03000010) begin
      n_fail++; $display("FAIL mode3_end: busy=%b cmdaddr=%h, required 0 03000010", busy, m_sr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_quad();
    test_zero_length();
    test_ignore_busy();
    test_reset_mid();
    test_mode3();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_data_q.size() != 0) begin
      n_fail++; $display("FAIL missing_bytes: %0d expected bytes never arrived, required 0", exp_data_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_reader_multi.md
Name: spi_flash_reader_multi

Overview:
Read-only SPI NOR flash master with selectable single, dual or quad data phase. It replaces the fixed single-bit MOSI/MISO flash link for bootloader and asset streaming. The block issues one read command per request, streams out the requested number of bytes on a valid-strobe interface, then releases CSN. It sits between the bootloader/CPU bus bridge and the flash pads, or the flash simulation model.

Parameters:
ADDRESS_WIDTH, 24, width of flash byte address; always sent as 24 bits, upper bits zero-extended/truncated
LENGTH_WIDTH, 16, width of byte-count request
DUMMY_CYCLES, 8, SCK periods of dummy phase for dual/quad reads; single mode has none
CSN_IDLE_CYCLES, 2, clk cycles CSN stays high after a transaction before busy drops

Ports:
clk  input  1  system clock; SCK = clk/2
reset  input  1  synchronous, active-high
mode  input  2  0 = single (cmd 0x03), 1 = dual output (0x3B), 2 = quad output (0x6B), 3 = treated as single; sampled at accept
read_start  input  1  request strobe; accepted only when busy=0
read_address  input  ADDRESS_WIDTH  start byte address, sampled at accept
read_length  input  LENGTH_WIDTH  byte count, sampled at accept
busy  output  1  high from cycle after accept until idle gap ends
data  output  8  received byte, MSB first
data_valid  output  1  one-cycle strobe per byte
flash_sck  output  1  SPI clock, idle low (mode 0)
flash_csn  output  1  chip select, active low
flash_io_out  output  4  io0..io3 drive values
flash_io_oe  output  4  io0..io3 output enables
flash_io_in  input  4  io0..io3 pad inputs (io1 = MISO in single mode)

Behaviour:
- Reset (any time, incl. mid-transaction): next cycle csn=1, sck=0, busy=0, data_valid=0, data=0, io_out=4'b1100, io_oe=4'b1101; state IDLE; counters cleared; no further data_valid.
- Pin defaults in IDLE/CSN gap: io2/io3 (WP#/HOLD#) driven 1, io0 driven 0, io1 released.
- Accept: cycle 0 has read_start=1, busy=0, read_length≠0. Latch mode/address/length. read_length=0: nothing happens, busy stays 0. read_start while busy: ignored.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DUMMY (dual/quad only, DUMMY_CYCLES periods) -> DATA -> GAP (CSN_IDLE_CYCLES) -> IDLE.
- Bit timing: each SCK period = 2 clk; first clk sck=0 with new output bits presented, second clk sck=1. Inputs are registered at the end of the sck=1 cycle. CSN falls in cycle 1 with sck=0 and cmd bit 7 on io0.
- CMD/ADDR always single-line on io0, MSB first, io0 oe=1.
- DUMMY/DATA: single keeps io0 oe=1, out=0, and samples io1. Dual releases io0/io1 and samples {io1,io0} (io1 = higher bit). Quad releases all four and samples io[3:0], io3 = highest bit. In single and dual modes io2/io3 stay driven high throughout.
- Bits per byte: 8 (single), 4 periods (dual), 2 periods (quad).
- data_valid and data update the cycle after the last sampling cycle of each byte.
- First data_valid at cycle 81 (single), 89 (dual), 85 (quad) with DUMMY_CYCLES=8. Later bytes follow every 16/8/4 clk.
- SCK runs continuously between bytes. No backpressure.
- After the final byte, csn=1 and sck=0 in the same cycle as the final data_valid. io pins return to IDLE defaults. busy falls CSN_IDLE_CYCLES cycles later.
- Length counter is decremented per byte. Address increments happen in flash; no wrap logic in the block.

Test Plan:
- Single, address 0x123456, length 2, model returns 0xA5, 0x3C -> io0 bitstream 0x03,0x12,0x34,0x56. data_valid at cycles 81 and 97 with data 0xA5, 0x3C. csn high at 97, busy low at 99.
- Dual, address 0x000100, length 3, model returns 0x11,0x22,0x33 -> cmd 0x3B, 8 dummy periods with io0/io1 oe=0. Bytes at cycles 89/97/105. io2/io3 out=1, oe=1 throughout.
- Quad, address 0xFFFFFF, length 1, model returns 0x9E -> cmd 0x6B, io_oe=0000 in DUMMY/DATA, data_valid at cycle 85 with 0x9E.
- read_length=0 -> csn stays 1, busy stays 0, no sck edges. Second read_start during an active read -> ignored, byte count unchanged.
- Assert reset at cycle 40 of a single read -> cycle 41: csn=1, sck=0, busy=0. A new read accepted afterwards completes normally.
- mode=3 -> identical waveform to mode=0 (cmd 0x03, no dummy).
